// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1/8N2 UART transmitter with a one-byte holding register for gapless back-to-back frames.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 tx_done
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = DATA_BITS > 1 ? $clog2(DATA_BITS) : 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, hold_q, hold_d;
  logic hold_full_q, hold_full_d, tx_out_q, tx_out_d, busy_q, busy_d, done_q, done_d;
  logic tick, last_bit, frame_end, load, accept;
  always_comb begin
    tick = baud_q == BAUD_W'(CLKS_PER_BIT - 1);
    last_bit = bit_q == BIT_W'(state_q == STOP ? STOP_BITS - 1 : DATA_BITS - 1);
    frame_end = state_q == STOP && tick && last_bit;
    load = hold_full_q && (state_q == IDLE || frame_end);
    accept = tx_valid && !hold_full_q;
    baud_d = (state_q == IDLE || tick) ? '0 : baud_q + 1'b1;
    bit_d = (state_q == IDLE || state_q == START || (tick && last_bit)) ? '0 : tick ? bit_q + 1'b1 : bit_q;
    shift_d = load ? hold_q : (state_q == DATA && tick) ? shift_q >> 1 : shift_q;
    state_d = load ? START
            : (state_q == START && tick) ? DATA
            : (state_q == DATA && tick && last_bit) ? STOP
            : frame_end ? IDLE : state_q;
    hold_d = accept ? tx_data : hold_q;
    hold_full_d = accept || (hold_full_q && !load);
    // line value follows the next state so tx_out stays a plain flop output
    tx_out_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
    busy_d = state_d != IDLE;
    done_d = frame_end;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      hold_q <= '0;
      hold_full_q <= 1'b0;
      tx_out_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      hold_q <= hold_d;
      hold_full_q <= hold_full_d;
      tx_out_q <= tx_out_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign tx_ready = !hold_full_q;
  assign tx_out = tx_out_q;
  assign busy = busy_q;
  assign tx_done = done_q;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: scenario tasks plus a serial-line receiver feeding a byte scoreboard.
module tb_uart_tx_serializer;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] tx_data = '0, tx_data2 = '0;
  logic tx_valid = 1'b0, tx_valid2 = 1'b0;
  logic tx_ready, tx_out, busy, tx_done;
  logic tx_ready2, tx_out2, busy2, tx_done2;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_tx_serializer dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_out(tx_out), .busy(busy), .tx_done(tx_done)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx_out(tx_out2), .busy(busy2), .tx_done(tx_done2)
  );

  // receiver: start-edge detect, then sample each 8-cycle bit at its centre
  always begin : rx_mon
    logic [7:0] b;
    logic ab;
    @(negedge clk);
    if (!reset && tx_out === 1'b0) begin
      ab = 1'b0;
      repeat (4) begin @(negedge clk); ab |= reset; end
      ab |= tx_out;
      for (int i = 0; i < 8; i++) begin
        repeat (8) begin @(negedge clk); ab |= reset; end
        b[i] = tx_out;
      end
      repeat (8) begin @(negedge clk); ab |= reset; end
      if (!ab) begin
        checks++;
        if (exp_q.size() == 0 || tx_out !== 1'b1 || b !== exp_q[0]) begin
          errors++;
          $display("FAIL scoreboard rx=%h stop=%b exp=%h pending=%0d", b, tx_out,
                   exp_q.size() != 0 ? exp_q[0] : 8'hxx, exp_q.size());
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n = 0;
    tx_data = b;
    tx_valid = 1'b1;
    exp_q.push_back(b);
    while (tx_ready !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 1000) begin errors++; $display("FAIL send_timeout byte=%h ready=%b exp=1", b, tx_ready); end
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL accept_ready got=%b exp=0", tx_ready); end
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL %s_drain pending=%0d exp=0", nm, exp_q.size()); end
  endtask

  // entered at the first sample after tx_out falls; leaves 80 samples later
  task automatic check_frame(input string nm, input logic [7:0] b, input logic busy_after);
    logic [9:0] fr, seen;
    int bad = 0, bbad = 0, dbad = 0;
    fr = {1'b1, b, 1'b0};
    seen = '0;
    for (int k = 0; k < 80; k++) begin
      if (tx_out !== fr[k/8]) bad++;
      if (k % 8 == 4) seen[k/8] = tx_out;
      if (busy !== 1'b1) bbad++;
      if (k > 0 && tx_done !== 1'b0) dbad++;
      @(negedge clk);
    end
    checks += 4;
    if (bad != 0) begin errors++; $display("FAIL %s_wave got=%b exp=%b badcycles=%0d", nm, seen, fr, bad); end
    if (bbad != 0) begin errors++; $display("FAIL %s_busy lowcycles=%0d exp=0", nm, bbad); end
    if (dbad != 0 || tx_done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done early=%0d at80=%b exp early=0 at80=1", nm, dbad, tx_done);
    end
    if (busy !== busy_after) begin errors++; $display("FAIL %s_busy_after got=%b exp=%b", nm, busy, busy_after); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks += 4;
    if (tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx_out got=%b exp=1", tx_out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", tx_done); end
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", tx_ready); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    send(8'hA5);
    checks += 2;
    if (tx_out !== 1'b1) begin errors++; $display("FAIL latency_tx_out got=%b exp=1", tx_out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL latency_busy got=%b exp=0", busy); end
    @(negedge clk);
    check_frame("single_a5", 8'hA5, 1'b0);
    @(negedge clk);
    checks++;
    if (tx_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got=%b exp=0", tx_done); end
    drain("single");
  endtask

  task automatic test_back_to_back();
    send(8'h00);
    tx_data = 8'hFF;
    tx_valid = 1'b1;
    exp_q.push_back(8'hFF);
    @(negedge clk);
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_load got=%b exp=1", tx_ready); end
    fork
      check_frame("b2b_00", 8'h00, 1'b1);
      begin
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        checks++;
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_held got=%b exp=0", tx_ready); end
        repeat (78) @(negedge clk);
        checks++;
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_late got=%b exp=0", tx_ready); end
      end
    join
    checks++;
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_second_load got=%b exp=1", tx_ready); end
    check_frame("b2b_ff", 8'hFF, 1'b0);
    drain("b2b");
  endtask

  task automatic test_backpressure();
    send(8'h11);
    send(8'h22);
    send(8'h33);
    drain("backpressure");
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    send(8'h5A);
    @(negedge clk);
    tx_data = 8'h77;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    checks++;
    if (tx_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_held got=%b exp=0", tx_ready); end
    repeat (34) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks += 4;
    if (tx_out !== 1'b1) begin errors++; $display("FAIL rst_mid_tx_out got=%b exp=1", tx_out); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", tx_ready); end
    if (tx_done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got=%b exp=0", tx_done); end
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    repeat (120) begin
      if (tx_done !== 1'b0 || tx_out !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_mid_quiet activecycles=%0d exp=0", bad); end
    send(8'h3C);
    @(negedge clk);
    check_frame("rst_mid_3c", 8'h3C, 1'b0);
    drain("rst_mid");
  endtask

  task automatic test_two_stop();
    logic [7:0] b = 8'h80;
    logic e;
    int bad = 0, dbad = 0;
    tx_data2 = b;
    tx_valid2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid2 = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 44; k++) begin
      e = k < 4 ? 1'b0 : k < 36 ? b[(k-4)/4] : 1'b1;
      if (tx_out2 !== e || busy2 !== 1'b1) bad++;
      if (k > 0 && tx_done2 !== 1'b0) dbad++;
      @(negedge clk);
    end
    checks += 3;
    if (bad != 0) begin errors++; $display("FAIL two_stop_wave badcycles=%0d exp=0", bad); end
    if (dbad != 0 || tx_done2 !== 1'b1) begin
      errors++;
      $display("FAIL two_stop_len early=%0d at44=%b exp early=0 at44=1", dbad, tx_done2);
    end
    if (busy2 !== 1'b0 || tx_out2 !== 1'b1) begin
      errors++;
      $display("FAIL two_stop_idle busy=%b tx_out=%b exp busy=0 tx_out=1", busy2, tx_out2);
    end
  endtask

  task automatic test_loopback();
    send(8'h00);
    send(8'h55);
    send(8'hC3);
    send(8'hFF);
    drain("loopback");
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_two_stop();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
